arty_input_debounce: RTL and testbench



---
 rtl/arty_io_pkg.sv | 25 ++
 rtl/debounce_ch.sv | 88 ++++++++
 rtl/arty_input_debounce.sv | 42 ++++
 tb/tb_arty_input_debounce.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/arty_io_pkg.sv
// rtl/arty_io_pkg.sv - shared Arty board I/O constants
// Purpose: channel indices, default debounce length and GPIO direction codes
//          used by the input conditioning stage and other board-level glue.
// Ports:   none (package).
package arty_io_pkg;

   // Board channel layout on the conditioned input bus.
   localparam int BTN_BASE = 0;
   localparam int SW_BASE  = 4;
   localparam int N_BTN    = 4;
   localparam int N_SW     = 4;

   // 2.5 ms at a 100 MHz core clock.
   localparam int DEBOUNCE_CYCLES_DEFAULT = 250000;

   // GPIO direction encoding.
   localparam logic GPIO_DIR_IN  = 1'b0;
   localparam logic GPIO_DIR_OUT = 1'b1;

   // Stability counter width; at least one bit so DEBOUNCE_CYCLES = 1 still elaborates.
   function automatic int cnt_width(input int cycles);
      return (cycles > 1) ? $clog2(cycles) : 1;
   endfunction

endpackage : arty_io_pkg

// File: rtl/debounce_ch.sv
// rtl/debounce_ch.sv - single-channel synchroniser and debouncer
// Purpose: two-flop synchroniser, stability counter, debounced level,
//          one-cycle rise/fall strobes and a sticky change flag.
// Ports:   clk, rst_n      clock and async active-low reset
//          raw_i           asynchronous pin
//          clr_i           clear for changed_o (level-sampled)
//          db_o            debounced level
//          rise_o, fall_o  one-cycle strobes on accepted transitions
//          changed_o       sticky transition flag
module debounce_ch
   import arty_io_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   input  logic clr_i,
   output logic db_o,
   output logic rise_o,
   output logic fall_o,
   output logic changed_o
);

   localparam int                 CNT_W   = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   (* ASYNC_REG = "TRUE" *) logic s1_q;
   (* ASYNC_REG = "TRUE" *) logic s2_q;
   logic             s1_d, s2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             db_q, db_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;
   logic             changed_q, changed_d;
   logic             accept;

   always_comb begin
      s1_d   = raw_i;
      s2_d   = s1_q;
      cnt_d  = cnt_q;
      db_d   = db_q;
      rise_d = 1'b0;
      fall_d = 1'b0;
      accept = 1'b0;
      if (s2_q == db_q) begin
         // Any cycle agreeing with the current level restarts the count.
         cnt_d = '0;
      end else if (cnt_q == CNT_MAX) begin
         accept = 1'b1;
         db_d   = s2_q;
         cnt_d  = '0;
         rise_d = s2_q;
         fall_d = ~s2_q;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      // A new transition wins over a simultaneous software clear.
      changed_d = accept | (changed_q & ~clr_i);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q      <= RESET_VAL;
         s2_q      <= RESET_VAL;
         cnt_q     <= '0;
         db_q      <= RESET_VAL;
         rise_q    <= 1'b0;
         fall_q    <= 1'b0;
         changed_q <= 1'b0;
      end else begin
         s1_q      <= s1_d;
         s2_q      <= s2_d;
         cnt_q     <= cnt_d;
         db_q      <= db_d;
         rise_q    <= rise_d;
         fall_q    <= fall_d;
         changed_q <= changed_d;
      end
   end

   assign db_o      = db_q;
   assign rise_o    = rise_q;
   assign fall_o    = fall_q;
   assign changed_o = changed_q;

endmodule : debounce_ch

// File: rtl/arty_input_debounce.sv
// rtl/arty_input_debounce.sv - Arty button/switch input conditioning stage
// Purpose: N_CH independent debounce channels feeding the SoC GPIO input bus.
// Ports:   clk, rst_n      clock and async active-low reset
//          raw_i           asynchronous board pins
//          clr_i           per-channel clear of changed_o
//          db_o            debounced levels (gpio_in)
//          rise_o, fall_o  one-cycle strobes per channel
//          changed_o       sticky per-channel change flags
module arty_input_debounce
   import arty_io_pkg::*;
#(
   parameter int              N_CH            = 8,
   parameter int              DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter logic [N_CH-1:0] RESET_VAL       = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [N_CH-1:0] raw_i,
   input  logic [N_CH-1:0] clr_i,
   output logic [N_CH-1:0] db_o,
   output logic [N_CH-1:0] rise_o,
   output logic [N_CH-1:0] fall_o,
   output logic [N_CH-1:0] changed_o
);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      debounce_ch #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_VAL       (RESET_VAL[i])
      ) u_ch (
         .clk       (clk),
         .rst_n     (rst_n),
         .raw_i     (raw_i[i]),
         .clr_i     (clr_i[i]),
         .db_o      (db_o[i]),
         .rise_o    (rise_o[i]),
         .fall_o    (fall_o[i]),
         .changed_o (changed_o[i])
      );
   end

endmodule : arty_input_debounce

// File: tb/tb_arty_input_debounce.sv
// tb/tb_arty_input_debounce.sv - self-checking bench for arty_input_debounce
module tb_arty_input_debounce;

   localparam int DC_A = 16;

   typedef struct {
      int         cyc;
      logic [7:0] rise;
      logic [7:0] fall;
      logic [7:0] db;
   } exp_t;

   logic       clk;
   logic       rst_a, rst_b;
   logic [7:0] raw_a, clr_a, db_a, rise_a, fall_a, chg_a;
   logic [7:0] raw_b, clr_b, db_b, rise_b, fall_b, chg_b;

   int   cyc;
   int   n_cmp;
   int   n_mis;
   exp_t sb[$];

   arty_input_debounce #(
      .N_CH            (8),
      .DEBOUNCE_CYCLES (DC_A),
      .RESET_VAL       (8'h00)
   ) u_dut_a (
      .clk       (clk),
      .rst_n     (rst_a),
      .raw_i     (raw_a),
      .clr_i     (clr_a),
      .db_o      (db_a),
      .rise_o    (rise_a),
      .fall_o    (fall_a),
      .changed_o (chg_a)
   );

   arty_input_debounce #(
      .N_CH            (8),
      .DEBOUNCE_CYCLES (1),
      .RESET_VAL       (8'h0F)
   ) u_dut_b (
      .clk       (clk),
      .rst_n     (rst_b),
      .raw_i     (raw_b),
      .clr_i     (clr_b),
      .db_o      (db_b),
      .rise_o    (rise_b),
      .fall_o    (fall_b),
      .changed_o (chg_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic wait_neg(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   // Change the pins at a falling edge, so the next rising edge is edge k and
   // the accepted transition is visible after edge k+1+DC_A.
   task automatic drive_a(input logic [7:0] v, input logic [7:0] r,
                          input logic [7:0] f, input logic [7:0] dbx);
      exp_t e;
      @(negedge clk);
      raw_a = v;
      if ((r | f) != 8'h00) begin
         e.cyc  = cyc + 2 + DC_A;
         e.rise = r;
         e.fall = f;
         e.db   = dbx;
         sb.push_back(e);
      end
   endtask

   // Scoreboard monitor for DUT A: every strobe must match the next expected event.
   always @(negedge clk) begin
      if (rst_a) begin
         if (sb.size() != 0 && sb[0].cyc < cyc) begin
            check("sb_missed_strobe_cycle", cyc, sb[0].cyc);
            void'(sb.pop_front());
         end
         if ((rise_a | fall_a) != 8'h00) begin
            if (sb.size() == 0) begin
               check("sb_unexpected_strobe", {16'h0, rise_a, fall_a}, 32'h0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("sb_strobe_cycle", cyc, e.cyc);
               check("sb_rise", rise_a, e.rise);
               check("sb_fall", fall_a, e.fall);
               check("sb_db", db_a, e.db);
               check("sb_changed_set", chg_a & (e.rise | e.fall), e.rise | e.fall);
            end
         end
      end
   end

   initial begin
      logic [7:0] gl_db   [5];
      logic [7:0] gl_rise [5];
      logic [7:0] gl_fall [5];

      n_cmp = 0;
      n_mis = 0;
      rst_a = 1'b0;
      rst_b = 1'b0;
      raw_a = 8'h00;
      clr_a = 8'h00;
      raw_b = 8'h0F;
      clr_b = 8'h00;

      // Reset state
      wait_neg(3);
      check("rst_db", db_a, 8'h00);
      check("rst_rise", rise_a, 8'h00);
      check("rst_fall", fall_a, 8'h00);
      check("rst_changed", chg_a, 8'h00);
      check("rst_b_db", db_b, 8'h0F);
      check("rst_b_strobes", rise_b | fall_b, 8'h00);
      rst_a = 1'b1;
      wait_neg(4);

      // Clean press on channel 0
      drive_a(8'h01, 8'h01, 8'h00, 8'h01);
      wait_neg(DC_A + 1);
      check("press_db_early", db_a, 8'h00);
      wait_neg(1);
      check("press_db", db_a, 8'h01);
      check("press_rise", rise_a, 8'h01);
      wait_neg(1);
      check("press_rise_clear", rise_a, 8'h00);
      check("press_changed", chg_a, 8'h01);
      wait_neg(5);

      // Bounce on channel 1: 5-cycle segments never reach DC_A
      for (int s = 0; s < 12; s++) begin
         @(negedge clk);
         raw_a[1] = (s % 2 == 0);
         wait_neg(4);
      end
      check("bounce_db", db_a, 8'h01);
      drive_a(8'h03, 8'h02, 8'h00, 8'h03);
      wait_neg(DC_A + 5);

      // Software clear takes effect after one edge
      @(negedge clk);
      clr_a = 8'h03;
      @(negedge clk);
      check("clr_changed", chg_a, 8'h00);
      clr_a = 8'h00;

      // Set beats a continuously held clear on channel 3
      clr_a = 8'h08;
      drive_a(8'h0B, 8'h08, 8'h00, 8'h0B);
      wait_neg(DC_A + 2);
      check("collide_set", chg_a[3], 1'b1);
      wait_neg(1);
      check("collide_clear", chg_a[3], 1'b0);
      clr_a = 8'h00;
      wait_neg(3);

      // Reset mid-count on channel 2
      drive_a(8'h0F, 8'h00, 8'h00, 8'h00);
      wait_neg(10);
      #2;
      rst_a = 1'b0;
      #1;
      check("midrst_db", db_a, 8'h00);
      check("midrst_changed", chg_a, 8'h00);
      check("midrst_strobes", rise_a | fall_a, 8'h00);
      wait_neg(3);
      check("midrst_db_hold", db_a, 8'h00);
      begin
         exp_t e;
         rst_a  = 1'b1;
         e.cyc  = cyc + 2 + DC_A;
         e.rise = 8'h0F;
         e.fall = 8'h00;
         e.db   = 8'h0F;
         sb.push_back(e);
      end
      wait_neg(DC_A + 1);
      check("midrst_db_early", db_a, 8'h00);
      wait_neg(6);

      // Multi-channel press and release
      drive_a(8'h00, 8'h00, 8'h0F, 8'h00);
      wait_neg(DC_A + 4);
      drive_a(8'hFF, 8'hFF, 8'h00, 8'hFF);
      wait_neg(DC_A + 4);
      drive_a(8'h00, 8'h00, 8'hFF, 8'h00);
      wait_neg(DC_A + 6);
      check("sb_drained", sb.size(), 0);

      // DEBOUNCE_CYCLES = 1 with RESET_VAL = 8'h0F
      check("b_rst_db", db_b, 8'h0F);
      rst_b = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b_idle_db", db_b, 8'h0F);
         check("b_idle_strobes", rise_b | fall_b, 8'h00);
      end
      gl_db   = '{8'h0F, 8'h0F, 8'h1F, 8'h0F, 8'h0F};
      gl_rise = '{8'h00, 8'h00, 8'h10, 8'h00, 8'h00};
      gl_fall = '{8'h00, 8'h00, 8'h00, 8'h10, 8'h00};
      @(negedge clk);
      raw_b = 8'h1F;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         raw_b = 8'h0F;
         check("b_glitch_db", db_b, gl_db[i]);
         check("b_glitch_rise", rise_b, gl_rise[i]);
         check("b_glitch_fall", fall_b, gl_fall[i]);
      end
      check("b_changed", chg_b, 8'h10);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule : tb_arty_input_debounce
